// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: opcodes, issue FSM states, and a
// register-usage decoder for instruction pairing.
package mips_pkg;

  localparam int unsigned OP_W  = 6;
  localparam int unsigned REG_W = 5;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_ADDIU = 6'h09;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  typedef enum logic [0:0] {
    S_PAIR   = 1'b0,
    S_SECOND = 1'b1
  } state_e;

  typedef struct packed {
    logic [REG_W-1:0] dest;   // 0 when the instruction writes no register
    logic [REG_W-1:0] src_a;
    logic [REG_W-1:0] src_b;
    logic             src_a_v;
    logic             src_b_v;
    logic             mem;
    logic             ctl;
  } dec_t;

  // Takes instruction bits [31:11]: opcode, rs, rt, rd.
  function automatic dec_t decode(input logic [20:0] hi);
    dec_t             d;
    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
    op = hi[20:15];
    rs = hi[14:10];
    rt = hi[9:5];
    rd = hi[4:0];
    d  = '0;
    case (op)
      OP_RTYPE: begin
        d.dest = rd; d.src_a = rs; d.src_a_v = 1'b1; d.src_b = rt; d.src_b_v = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI: begin
        d.dest = rt; d.src_a = rs; d.src_a_v = 1'b1;
      end
      OP_LUI: d.dest = rt;
      OP_LW: begin
        d.dest = rt; d.src_a = rs; d.src_a_v = 1'b1; d.mem = 1'b1;
      end
      OP_SW: begin
        d.src_a = rs; d.src_a_v = 1'b1; d.src_b = rt; d.src_b_v = 1'b1; d.mem = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        d.src_a = rs; d.src_a_v = 1'b1; d.src_b = rt; d.src_b_v = 1'b1; d.ctl = 1'b1;
      end
      OP_J:   d.ctl = 1'b1;
      OP_JAL: begin
        d.dest = 5'd31; d.ctl = 1'b1;
      end
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/pair_hazard_check.sv
// Decides whether two sequential instructions can issue in the same cycle;
// reason bits are exposed for observation.
module pair_hazard_check
  import mips_pkg::*;
(
  input  logic [31:0] instr1,
  input  logic [31:0] instr2,
  output logic        conflict,
  output logic        raw,
  output logic        waw,
  output logic        mem,
  output logic        ctl
);

  dec_t d1;
  dec_t d2;
  logic unused_imm;

  assign d1 = decode(instr1[31:11]);
  assign d2 = decode(instr2[31:11]);
  assign unused_imm = ^{instr1[10:0], instr2[10:0]};

  // $0 as a destination never creates a dependency.
  assign raw = (d1.dest != '0) &&
               ((d2.src_a_v && (d2.src_a == d1.dest)) ||
                (d2.src_b_v && (d2.src_b == d1.dest)));
  assign waw = (d1.dest != '0) && (d1.dest == d2.dest);
  assign mem = d1.mem & d2.mem;
  assign ctl = d1.ctl;

  assign conflict = raw | waw | mem | ctl;

endmodule

// File: rtl/dual_issue_ctrl.sv
// Dual-issue pairing controller: issues fetched pairs together or splits
// them across two cycles, stalling fetch and counting splits.
module dual_issue_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instrf,
  input  logic [31:0]      instrf2,
  input  logic             fvalid,
  input  logic             stalld,
  input  logic             redirect,
  output logic             stallf,
  output logic [31:0]      instrd,
  output logic [31:0]      instrd2,
  output logic             validd,
  output logic             validd2,
  output logic [CNT_W-1:0] split_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state, state_nx;
  logic [31:0]      hold, hold_nx;
  logic [31:0]      instrd_nx, instrd2_nx;
  logic             validd_nx, validd2_nx;
  logic [CNT_W-1:0] cnt_nx;
  logic             conflict;
  logic             hz_raw, hz_waw, hz_mem, hz_ctl;
  logic             unused_hz;

  pair_hazard_check u_hazard (
    .instr1   (instrf),
    .instr2   (instrf2),
    .conflict (conflict),
    .raw      (hz_raw),
    .waw      (hz_waw),
    .mem      (hz_mem),
    .ctl      (hz_ctl)
  );

  assign unused_hz = ^{hz_raw, hz_waw, hz_mem, hz_ctl};

  // State and issue registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_PAIR;
      hold      <= '0;
      instrd    <= '0;
      instrd2   <= '0;
      validd    <= 1'b0;
      validd2   <= 1'b0;
      split_cnt <= '0;
    end else begin
      state     <= state_nx;
      hold      <= hold_nx;
      instrd    <= instrd_nx;
      instrd2   <= instrd2_nx;
      validd    <= validd_nx;
      validd2   <= validd2_nx;
      split_cnt <= cnt_nx;
    end
  end

  // Next-state, issue selection and fetch stall
  always_comb begin
    state_nx   = state;
    hold_nx    = hold;
    instrd_nx  = instrd;
    instrd2_nx = instrd2;
    validd_nx  = validd;
    validd2_nx = validd2;
    cnt_nx     = split_cnt;
    stallf     = stalld;
    if (!stalld) begin
      if (state == S_SECOND) begin
        // The held slot issues even under redirect: it is the delay slot.
        instrd_nx  = hold;
        validd_nx  = 1'b1;
        instrd2_nx = '0;
        validd2_nx = 1'b0;
        state_nx   = S_PAIR;
      end else if (redirect || !fvalid) begin
        instrd_nx  = '0;
        validd_nx  = 1'b0;
        instrd2_nx = '0;
        validd2_nx = 1'b0;
      end else if (!conflict) begin
        instrd_nx  = instrf;
        validd_nx  = 1'b1;
        instrd2_nx = instrf2;
        validd2_nx = 1'b1;
      end else begin
        instrd_nx  = instrf;
        validd_nx  = 1'b1;
        instrd2_nx = '0;
        validd2_nx = 1'b0;
        hold_nx    = instrf2;
        stallf     = 1'b1;
        state_nx   = S_SECOND;
        if (split_cnt != CNT_MAX) cnt_nx = split_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dual_issue_ctrl.sv
// Directed bench for dual_issue_ctrl: expected issue results are queued when
// each fetch pair is driven and checked after the following clock edge.
module tb_dual_issue_ctrl;

  localparam int unsigned CW = 4;

  localparam logic [31:0] ADD3  = 32'h0022_1820; // add  $3,$1,$2
  localparam logic [31:0] SUB6  = 32'h0085_3022; // sub  $6,$4,$5
  localparam logic [31:0] ADDI8 = 32'h2008_0005; // addi $8,$0,5
  localparam logic [31:0] ADD9  = 32'h0108_4820; // add  $9,$8,$8
  localparam logic [31:0] ADDI0 = 32'h2000_0005; // addi $0,$0,5
  localparam logic [31:0] ADD90 = 32'h0000_4820; // add  $9,$0,$0
  localparam logic [31:0] LW2   = 32'h8C22_0000; // lw   $2,0($1)
  localparam logic [31:0] SW3   = 32'hAC23_0004; // sw   $3,4($1)
  localparam logic [31:0] BEQ   = 32'h1022_0003; // beq  $1,$2,3
  localparam logic [31:0] ADDI4 = 32'h2084_0001; // addi $4,$4,1

  typedef struct packed {
    logic [31:0]   i1;
    logic [31:0]   i2;
    logic          v1;
    logic          v2;
    logic [CW-1:0] cnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [31:0]   instrf = '0;
  logic [31:0]   instrf2 = '0;
  logic          fvalid = 1'b0;
  logic          stalld = 1'b0;
  logic          redirect = 1'b0;
  logic          stallf;
  logic [31:0]   instrd;
  logic [31:0]   instrd2;
  logic          validd;
  logic          validd2;
  logic [CW-1:0] split_cnt;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  dual_issue_ctrl #(.CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .instrf    (instrf),
    .instrf2   (instrf2),
    .fvalid    (fvalid),
    .stalld    (stalld),
    .redirect  (redirect),
    .stallf    (stallf),
    .instrd    (instrd),
    .instrd2   (instrd2),
    .validd    (validd),
    .validd2   (validd2),
    .split_cnt (split_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] i1, input logic [31:0] i2,
                              input logic v1, input logic v2, input logic [CW-1:0] cnt);
    exp_t e;
    e.i1 = i1; e.i2 = i2; e.v1 = v1; e.v2 = v2; e.cnt = cnt;
    return e;
  endfunction

  // Drive one cycle of fetch/control inputs, check the combinational stall and
  // hazard reasons ({raw,waw,mem,ctl}), then score the registered issue lanes.
  task automatic step(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic fv, input logic sd, input logic rd, input logic rst,
                      input logic exp_stf, input logic [3:0] exp_hz, input exp_t e);
    exp_t got;
    @(negedge clk);
    instrf = a; instrf2 = b; fvalid = fv; stalld = sd; redirect = rd; reset = rst;
    #1;
    chk({tag, ".stallf"}, 32'(stallf), 32'(exp_stf));
    chk({tag, ".hazard"}, 32'({dut.u_hazard.raw, dut.u_hazard.waw,
                               dut.u_hazard.mem, dut.u_hazard.ctl}), 32'(exp_hz));
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'd0, 32'd1);
    end else begin
      got = sb.pop_front();
      chk({tag, ".instrd"}, instrd, got.i1);
      chk({tag, ".instrd2"}, instrd2, got.i2);
      chk({tag, ".validd"}, 32'(validd), 32'(got.v1));
      chk({tag, ".validd2"}, 32'(validd2), 32'(got.v2));
      chk({tag, ".split_cnt"}, 32'(split_cnt), 32'(got.cnt));
    end
  endtask

  initial begin
    logic [CW-1:0] c;
    step("reset", '0, '0, 0, 0, 0, 1, 0, 4'b0000, mk('0, '0, 0, 0, 0));
    step("indep", ADD3, SUB6, 1, 0, 0, 0, 0, 4'b0000, mk(ADD3, SUB6, 1, 1, 0));
    step("idle", '0, '0, 0, 0, 0, 0, 0, 4'b0000, mk('0, '0, 0, 0, 0));
    step("raw1", ADDI8, ADD9, 1, 0, 0, 0, 1, 4'b1000, mk(ADDI8, '0, 1, 0, 1));
    step("raw2", ADDI8, ADD9, 1, 0, 0, 0, 0, 4'b1000, mk(ADD9, '0, 1, 0, 1));
    step("dest0", ADDI0, ADD90, 1, 0, 0, 0, 0, 4'b0000, mk(ADDI0, ADD90, 1, 1, 1));
    step("mem1", LW2, SW3, 1, 0, 0, 0, 1, 4'b0010, mk(LW2, '0, 1, 0, 2));
    step("mem2", LW2, SW3, 1, 0, 0, 0, 0, 4'b0010, mk(SW3, '0, 1, 0, 2));
    step("br1", BEQ, ADDI4, 1, 0, 0, 0, 1, 4'b0001, mk(BEQ, '0, 1, 0, 3));
    step("br2_redir", BEQ, ADDI4, 1, 0, 1, 0, 0, 4'b0001, mk(ADDI4, '0, 1, 0, 3));
    step("redir_pair", LW2, SW3, 1, 0, 1, 0, 0, 4'b0010, mk('0, '0, 0, 0, 3));
    step("indep2", ADD3, SUB6, 1, 0, 0, 0, 0, 4'b0000, mk(ADD3, SUB6, 1, 1, 3));
    step("stall_redir", LW2, SW3, 1, 1, 1, 0, 1, 4'b0010, mk(ADD3, SUB6, 1, 1, 3));
    step("stall_more", BEQ, ADDI4, 1, 1, 0, 0, 1, 4'b0001, mk(ADD3, SUB6, 1, 1, 3));
    step("pre_rst", BEQ, ADDI4, 1, 0, 0, 0, 1, 4'b0001, mk(BEQ, '0, 1, 0, 4));
    step("rst_mid", BEQ, ADDI4, 1, 0, 0, 1, 0, 4'b0001, mk('0, '0, 0, 0, 0));
    step("post_rst", '0, '0, 0, 0, 0, 0, 0, 4'b0000, mk('0, '0, 0, 0, 0));
    step("post_rst_pair", ADD3, SUB6, 1, 0, 0, 0, 0, 4'b0000, mk(ADD3, SUB6, 1, 1, 0));
    for (int k = 0; k < 20; k++) begin
      c = (k + 1 >= 15) ? CW'(15) : CW'(k + 1);
      step("sat1", LW2, SW3, 1, 0, 0, 0, 1, 4'b0010, mk(LW2, '0, 1, 0, c));
      step("sat2", LW2, SW3, 1, 0, 0, 0, 0, 4'b0010, mk(SW3, '0, 1, 0, c));
    end
    chk("sat_final", 32'(split_cnt), 32'd15);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dual_issue_ctrl.md
# dual_issue_ctrl

Pairing/issue controller for the dual-fetch front end. Each cycle the fetch stage delivers two sequential instructions (`instrf`, `instrf2`, PC advancing by 8); this block decides whether the pair can issue together or must be split across two cycles. It drives the fetch stall, registers the issue lanes into decode, squashes wrong-path pairs on redirect, and counts split events.

## Interface
Parameters
- `CNT_W`, 16, width of the split-event performance counter

Ports
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `instrf`  in  32  fetched instruction, slot 1 (lower address)
- `instrf2`  in  32  fetched instruction, slot 2 (PC+4)
- `fvalid`  in  1  fetched pair valid
- `stalld`  in  1  decode stall; freeze all issue state
- `redirect`  in  1  decode resolved taken branch/jump (pcsrcd≠0); current fetch pair is wrong-path
- `stallf`  out  1  hold PC register (combinational)
- `instrd`  out  32  issued lane-1 instruction (registered)
- `instrd2`  out  32  issued lane-2 instruction (registered)
- `validd`  out  1  lane 1 valid
- `validd2`  out  1  lane 2 valid
- `split_cnt`  out  CNT_W  saturating count of split pairs

## Operation
- Decode classes by opcode `[31:26]`: R-type 0x00 (dest rd, src rs, rt); I-ALU 0x08/09/0A/0C/0D/0F (dest rt, src rs; 0x0F reads no source); lw 0x23 (dest rt, src rs); sw 0x2B (src rs, rt); beq/bne 0x04/0x05 (src rs, rt); j 0x02; jal 0x03 (dest r31). Any other opcode: no dest, no src.
- Conflict (split required) if any of:
  - RAW: slot 1 dest ≠ 0 and equals a source of slot 2
  - WAW: both dests ≠ 0 and equal
  - both are memory ops (single data port)
  - slot 1 is branch/jump (slot 2 is its delay slot and issues alone next cycle)
- FSM states: `S_PAIR`, `S_SECOND`.
- `S_PAIR`, `fvalid`, no conflict: issue both (`validd`=`validd2`=1). Stay.
- `S_PAIR`, `fvalid`, conflict: issue `instrf` on lane 1 only. Latch `instrf2` into the hold register. Assert `stallf`. Increment `split_cnt` (saturates at all-ones). Go to `S_SECOND`.
- `S_SECOND`: issue held instruction on lane 1, lane 2 invalid. `stallf`=0. Go to `S_PAIR`.
- `S_PAIR`, `!fvalid`: both lanes invalid.
- `redirect` in `S_PAIR`: pair is squashed. Both lanes invalid next cycle, no state change, no count.
- `redirect` in `S_SECOND`: ignored. The held delay-slot instruction still issues.
- `stalld`:
  - issue registers, state, hold register and counter all hold
  - `stallf`=1
  - takes priority over `redirect` and `fvalid`
- Invalid lanes drive instruction 0x00000000 (nop).

## Timing
- Issue latency: one cycle, from fetch outputs to `instrd`/`validd`.
- `stallf` is combinational. It is 1 when `stalld`, or when in `S_PAIR` with `fvalid` & conflict & !`redirect`.
- A split costs exactly one extra cycle: PC is held one cycle, then advances by 8.
- Reset values:
  - state `S_PAIR`
  - `instrd`/`instrd2`/hold register = 0
  - `validd`/`validd2` = 0
  - `split_cnt` = 0
  - `stallf` = 0 (when `stalld` is 0)
- Reset mid-split (in `S_SECOND`) discards the held instruction.

## Structure
- Shared package `mips_pkg`:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL, I-ALU set)
  - FSM state enum
- One combinational sub-module, `pair_hazard_check`. It takes (instr1, instr2) and returns `conflict` plus reason bits (raw, waw, mem, ctl) for the bench to observe.
- Top holds the FSM, issue/hold registers and counter.

## Test plan
- Independent pair: `add $3,$1,$2` + `sub $6,$4,$5`, `fvalid`=1 → next cycle `validd`=`validd2`=1, `stallf`=0 throughout, `split_cnt`=0.
- RAW: `addi $8,$0,5` + `add $9,$8,$8` → cycle 1 lane 1 only with `stallf`=1; cycle 2 lane 1 = `add`, lane 2 invalid; `split_cnt`=1. The same pattern with dest $0 must not split.
- Memory pair and branch-first: `lw $2,0($1)` + `sw $3,4($1)` splits. `beq $1,$2,off` + `addi $4,$4,1` splits, and `redirect` asserted during `S_SECOND` still issues `addi`.
- Redirect in `S_PAIR` with a conflicting pair → both lanes invalid, no stall, count unchanged. `stalld`+`redirect` together → outputs frozen, `stallf`=1.
- Saturation: `CNT_W`=4, 20 consecutive conflicting pairs → `split_cnt` stops at 15.
- Reset asserted while in `S_SECOND` → next cycle state `S_PAIR`, all valids 0, held instruction never issued.
